// File: rtl/gate_guard.sv
// gate_guard: final gate-drive protection stage between DPWM and drivers.
// Enforces dead time, blocks shoot-through and latches over-current faults.
module gate_guard #(
   parameter int unsigned MIN_DT   = 4,
   parameter int unsigned FLT_FILT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_c1,
   input  logic       i_c2,
   input  logic       i_ocp,
   input  logic       i_fault_clr,
   output logic       o_g1,
   output logic       o_g2,
   output logic       o_fault,
   output logic [1:0] o_fault_code
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [3:0] DT_MAX = 4'(MIN_DT);
   localparam logic [3:0] OC_MAX = 4'(FLT_FILT);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] dt_q;
   logic [3:0] dt_d;
   logic [3:0] oc_q;
   logic [3:0] oc_d;
   logic       ocp_m;
   logic       ocp_s;
   logic       g1_q;
   logic       g1_d;
   logic       g2_q;
   logic       g2_d;
   logic       flt_q;
   logic       flt_d;
   logic [1:0] code_q;
   logic [1:0] code_d;
   logic       st_hit;
   logic       oc_hit;
   logic       dt_ok;

   // i_ocp comes straight from an analog comparator
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ocp_m <= 1'b0;
         ocp_s <= 1'b0;
      end else begin
         ocp_m <= i_ocp;
         ocp_s <= ocp_m;
      end
   end

   always_comb begin
      oc_d = 4'd0;
      if (ocp_s) begin
         if (oc_q == OC_MAX) begin
            oc_d = OC_MAX;
         end else begin
            oc_d = oc_q + 4'd1;
         end
      end
   end

   // trips on the cycle the filter count reaches its limit
   assign oc_hit = (oc_d == OC_MAX);
   assign st_hit = i_c1 & i_c2;
   assign dt_ok  = (dt_q == DT_MAX);

   always_comb begin
      state_d = state_q;
      g1_d    = 1'b0;
      g2_d    = 1'b0;
      flt_d   = flt_q;
      code_d  = code_q;
      unique case (state_q)
         IDLE: begin
            if (i_en && !i_c1 && !i_c2) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (st_hit || oc_hit) begin
               state_d = FAULT;
               flt_d   = 1'b1;
               code_d  = {oc_hit, st_hit};
            end else if (!i_en) begin
               state_d = IDLE;
            end else begin
               g1_d = i_c1 & (g1_q | (dt_ok & ~g2_q));
               g2_d = i_c2 & (g2_q | (dt_ok & ~g1_q));
            end
         end
         FAULT: begin
            if (i_fault_clr && !ocp_s) begin
               state_d = IDLE;
               flt_d   = 1'b0;
               code_d  = 2'b00;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // dt_q reads 0 whenever a gate is on, else counts low cycles
   always_comb begin
      dt_d = 4'd0;
      if (!(g1_d || g2_d)) begin
         dt_d = dt_ok ? DT_MAX : dt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         dt_q    <= 4'd0;
         oc_q    <= 4'd0;
         g1_q    <= 1'b0;
         g2_q    <= 1'b0;
         flt_q   <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         dt_q    <= dt_d;
         oc_q    <= oc_d;
         g1_q    <= g1_d;
         g2_q    <= g2_d;
         flt_q   <= flt_d;
         code_q  <= code_d;
      end
   end

   assign o_g1         = g1_q;
   assign o_g2         = g2_q;
   assign o_fault      = flt_q;
   assign o_fault_code = code_q;

endmodule

// File: tb/tb_gate_guard.sv
// tb_gate_guard: directed scenarios for gate_guard.
// Gate overlap and dead time are also watched every cycle.
module tb_gate_guard;

   localparam int MIN_DT = 4;

   logic       clk  = 1'b0;
   logic       rst  = 1'b0;
   logic       en   = 1'b0;
   logic       c1   = 1'b0;
   logic       c2   = 1'b0;
   logic       ocp  = 1'b0;
   logic       clr  = 1'b0;
   logic       g1;
   logic       g2;
   logic       flt;
   logic [1:0] code;
   logic [4:0] obs;

   int n_chk  = 0;
   int n_fail = 0;
   int lowc   = 0;
   logic pg1  = 1'b0;
   logic pg2  = 1'b0;

   gate_guard #(.MIN_DT(4), .FLT_FILT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_en         (en),
      .i_c1         (c1),
      .i_c2         (c2),
      .i_ocp        (ocp),
      .i_fault_clr  (clr),
      .o_g1         (g1),
      .o_g2         (g2),
      .o_fault      (flt),
      .o_fault_code (code)
   );

   always #5 clk = ~clk;

   assign obs = {g1, g2, flt, code};

   // gate invariants, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         lowc = 0;
         pg1  = 1'b0;
         pg2  = 1'b0;
      end else begin
         n_chk++;
         assert (!(g1 && g2)) else begin
            n_fail++;
            $display("FAIL overlap: g1=%b g2=%b required not both 1", g1, g2);
         end
         n_chk++;
         assert (!(((g1 && !pg1) || (g2 && !pg2)) && lowc < MIN_DT)) else begin
            n_fail++;
            $display("FAIL dead_time: low run %0d required >= %0d", lowc, MIN_DT);
         end
         lowc = (g1 || g2) ? 0 : ((lowc < 100) ? lowc + 1 : lowc);
         pg1  = g1;
         pg2  = g2;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; c1 = 1'b1;
      step(3);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL reset_hold: got %b want %b", obs, 5'b00000);
      end
      en = 1'b0; c1 = 1'b0;
      step(1);
      rst = 1'b1;
      step(6);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL reset_idle: got %b want %b", obs, 5'b00000);
      end
   endtask

   task automatic test_clean_pwm();
      en = 1'b1;
      step(1);
      c1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         n_chk++;
         if (obs !== 5'b10000) begin
            n_fail++; $display("FAIL pwm_c1[%0d]: got %b want %b", i, obs, 5'b10000);
         end
      end
      c1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         n_chk++;
         if (obs !== 5'b00000) begin
            n_fail++; $display("FAIL pwm_gap[%0d]: got %b want %b", i, obs, 5'b00000);
         end
      end
      c2 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         n_chk++;
         if (obs !== 5'b01000) begin
            n_fail++; $display("FAIL pwm_c2[%0d]: got %b want %b", i, obs, 5'b01000);
         end
      end
      c2 = 1'b0;
      step(1);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL pwm_end: got %b want %b", obs, 5'b00000);
      end
   endtask

   task automatic test_dead_time();
      logic [4:0] want [0:2];
      want[0] = 5'b00000; want[1] = 5'b00000; want[2] = 5'b01000;
      step(5);
      c1 = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b10000) begin
         n_fail++; $display("FAIL dt_c1_on: got %b want %b", obs, 5'b10000);
      end
      step(3);
      c1 = 1'b0;
      step(1);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL dt_c1_fall: got %b want %b", obs, 5'b00000);
      end
      step(1);
      c2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         n_chk++;
         if (obs !== want[i]) begin
            n_fail++; $display("FAIL dt_hold[%0d]: got %b want %b", i, obs, want[i]);
         end
      end
      step(2);
      c2 = 1'b0;
      step(1);
      c2 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(1);
         n_chk++;
         if (obs !== 5'b00000) begin
            n_fail++; $display("FAIL dt_glitch[%0d]: got %b want %b", i, obs, 5'b00000);
         end
      end
      c2 = 1'b0;
      step(4);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL dt_dropped: got %b want %b", obs, 5'b00000);
      end
      c2 = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b01000) begin
         n_fail++; $display("FAIL dt_c2_after: got %b want %b", obs, 5'b01000);
      end
      c2 = 1'b0;
      step(1);
   endtask

   task automatic test_enable_drop();
      step(5);
      c1 = 1'b1;
      step(1);
      en = 1'b0;
      step(1);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL en_drop: got %b want %b", obs, 5'b00000);
      end
      step(1);
      en = 1'b1;
      step(3);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL idle_not_clean: got %b want %b", obs, 5'b00000);
      end
      c1 = 1'b0;
      step(1);
      c1 = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b10000) begin
         n_fail++; $display("FAIL en_rerun: got %b want %b", obs, 5'b10000);
      end
      c1 = 1'b0;
      step(1);
   endtask

   task automatic test_shoot_through();
      step(5);
      c1 = 1'b1;
      step(1);
      c2 = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b00101) begin
         n_fail++; $display("FAIL st_trip: got %b want %b", obs, 5'b00101);
      end
      c1 = 1'b0; c2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en = ~en;
         step(1);
         n_chk++;
         if (obs !== 5'b00101) begin
            n_fail++; $display("FAIL st_en_toggle[%0d]: got %b want %b", i, obs, 5'b00101);
         end
      end
      en = 1'b1; c1 = 1'b1;
      step(2);
      n_chk++;
      if (obs !== 5'b00101) begin
         n_fail++; $display("FAIL st_gated: got %b want %b", obs, 5'b00101);
      end
      c1 = 1'b0; clr = 1'b1;
      step(1);
      clr = 1'b0;
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL st_clear: got %b want %b", obs, 5'b00000);
      end
   endtask

   task automatic test_ocp_filter();
      step(6);
      ocp = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i == 3) ocp = 1'b0;
         step(1);
         n_chk++;
         if (obs !== 5'b00000) begin
            n_fail++; $display("FAIL ocp_short[%0d]: got %b want %b", i, obs, 5'b00000);
         end
      end
      ocp = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         n_chk++;
         if (obs !== ((i == 6) ? 5'b00110 : 5'b00000)) begin
            n_fail++;
            $display("FAIL ocp_trip[%0d]: got %b want %b", i, obs,
                     (i == 6) ? 5'b00110 : 5'b00000);
         end
      end
   endtask

   task automatic test_fault_clear();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      n_chk++;
      if (obs !== 5'b00110) begin
         n_fail++; $display("FAIL clr_ignored: got %b want %b", obs, 5'b00110);
      end
      step(2);
      ocp = 1'b0;
      step(3);
      en = 1'b1; c1 = 1'b1; clr = 1'b1;
      step(1);
      clr = 1'b0;
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL clr_taken: got %b want %b", obs, 5'b00000);
      end
      step(4);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL clr_idle_hold: got %b want %b", obs, 5'b00000);
      end
      c1 = 1'b0;
      step(1);
      c1 = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b10000) begin
         n_fail++; $display("FAIL clr_rerun: got %b want %b", obs, 5'b10000);
      end
      c1 = 1'b0;
      step(1);
   endtask

   task automatic test_idle_ocp();
      en = 1'b0;
      step(1);
      ocp = 1'b1;
      step(10);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL idle_ocp: got %b want %b", obs, 5'b00000);
      end
      en = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL idle_ocp_entry: got %b want %b", obs, 5'b00000);
      end
      step(1);
      n_chk++;
      if (obs !== 5'b00110) begin
         n_fail++; $display("FAIL idle_ocp_first_run: got %b want %b", obs, 5'b00110);
      end
      ocp = 1'b0; en = 1'b0;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   task automatic test_both_codes();
      en = 1'b1;
      step(6);
      ocp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         n_chk++;
         if (obs !== 5'b00000) begin
            n_fail++; $display("FAIL both_pre[%0d]: got %b want %b", i, obs, 5'b00000);
         end
      end
      c1 = 1'b1; c2 = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b00111) begin
         n_fail++; $display("FAIL both_code: got %b want %b", obs, 5'b00111);
      end
      c1 = 1'b0; c2 = 1'b0; ocp = 1'b0;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL both_clear: got %b want %b", obs, 5'b00000);
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      step(6);
      c1 = 1'b1;
      step(1);
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL rst_mid_pulse: got %b want %b", obs, 5'b00000);
      end
      c1 = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
      c1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         n_chk++;
         if (obs !== ((i == 3) ? 5'b10000 : 5'b00000)) begin
            n_fail++;
            $display("FAIL rst_first_pulse[%0d]: got %b want %b", i, obs,
                     (i == 3) ? 5'b10000 : 5'b00000);
         end
      end
      c2 = 1'b1;
      step(1);
      n_chk++;
      if (obs !== 5'b00101) begin
         n_fail++; $display("FAIL rst_pre_fault: got %b want %b", obs, 5'b00101);
      end
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL rst_in_fault: got %b want %b", obs, 5'b00000);
      end
      c1 = 1'b0; c2 = 1'b0;
      step(2);
      rst = 1'b1;
      step(6);
      n_chk++;
      if (obs !== 5'b00000) begin
         n_fail++; $display("FAIL rst_after: got %b want %b", obs, 5'b00000);
      end
   endtask

   initial begin
      test_reset();
      test_clean_pwm();
      test_dead_time();
      test_enable_drop();
      test_shoot_through();
      test_ocp_filter();
      test_fault_clear();
      test_idle_ocp();
      test_both_codes();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
